// File: rtl/result_fifo_pkg.sv
// Shared defaults, pointer/count width derivation and frame FSM encoding for result_fifo.
package result_fifo_pkg;

  localparam int unsigned WIDTH_DEF = 21;
  localparam int unsigned DEPTH_DEF = 8;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the count can represent DEPTH itself.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return ptr_w(depth) + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } frame_state_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array, one write port, one registered read port (1-cycle latency).
// No backpressure: callers gate wr_en/rd_en; only the read register is reset.
module fifo_mem
  import result_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW   = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Holds its value between reads so the popped word stays visible downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/result_fifo.sv
// Result FIFO with frame tracking: 1-cycle read latency, registered rd_data/rd_valid.
// Writes to a full FIFO are dropped and flagged in sticky overflow; reads of an empty FIFO are ignored.
module result_fifo
  import result_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW   = ptr_w(DEPTH),
  localparam int unsigned CW   = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             done,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             frame_done
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;
  logic [CW-1:0] count_nxt;
  frame_state_t  state;
  frame_state_t  state_nxt;
  logic          frame_done_nxt;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  // Full with both requests: the read wins and the write is dropped.
  assign wr_acc = wr_req && !full;
  assign rd_acc = rd_req && !empty;

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + 1'b1;
    end else if (!wr_acc && rd_acc) begin
      count_nxt = count - 1'b1;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count_nxt;
      rd_valid <= rd_acc;
      if (wr_req && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // Frame tracking only observes accepts; it never gates data flow.
  always_comb begin
    state_nxt      = state;
    frame_done_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_acc) begin
          state_nxt = done ? DRAIN : FILL;
        end else if (done) begin
          frame_done_nxt = 1'b1;
        end
      end
      FILL: begin
        if (done) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (count_nxt == '0) begin
          state_nxt      = IDLE;
          frame_done_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_result_fifo.sv
// Directed bench for result_fifo with a queue scoreboard and a reference model of count/overflow.
module tb_result_fifo;
  import result_fifo_pkg::*;

  localparam int unsigned W  = WIDTH_DEF;
  localparam int unsigned D  = 8;
  localparam int unsigned CW = cnt_w(D);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_req = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          done = 1'b0;
  logic          rd_req = 1'b0;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          frame_done;

  always #5 clk = ~clk;

  result_fifo #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .done       (done),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];
  int           m_count  = 0;
  logic         m_ovf    = 1'b0;
  logic [W-1:0] m_rd     = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_vld, input logic exp_fd);
    check({tag, ".rd_valid"},   32'(rd_valid),   32'(exp_vld));
    check({tag, ".rd_data"},    32'(rd_data),    32'(m_rd));
    check({tag, ".count"},      32'(count),      32'(m_count));
    check({tag, ".empty"},      32'(empty),      32'(m_count == 0));
    check({tag, ".full"},       32'(full),       32'(m_count == D));
    check({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
    check({tag, ".frame_done"}, 32'(frame_done), 32'(exp_fd));
  endtask

  // One clock of stimulus; the model decides acceptance from its own count.
  task automatic cycle(input string tag, input logic wr, input logic [W-1:0] d,
                       input logic rd, input logic dn, input logic exp_fd);
    logic m_wacc;
    logic m_racc;
    m_wacc  = wr && (m_count < D);
    m_racc  = rd && (m_count > 0);
    wr_req  = wr;
    wr_data = d;
    rd_req  = rd;
    done    = dn;
    @(posedge clk);
    #1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    done   = 1'b0;
    if (m_racc) m_rd = exp_q.pop_front();
    if (m_wacc) exp_q.push_back(d);
    if (wr && !m_wacc) m_ovf = 1'b1;
    m_count = m_count + (m_wacc ? 1 : 0) - (m_racc ? 1 : 0);
    check_all(tag, m_racc, exp_fd);
  endtask

  // Reset for one cycle, optionally with every other request asserted alongside it.
  task automatic do_reset(input string tag, input logic with_req);
    rst     = 1'b1;
    wr_req  = with_req;
    wr_data = 21'h155;
    rd_req  = with_req;
    done    = with_req;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    done   = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_rd    = '0;
    check_all(tag, 1'b0, 1'b0);
  endtask

  initial begin
    do_reset("reset", 1'b0);

    // Basic write/read ordering including an all-ones word.
    cycle("b_wr0", 1'b1, 21'h00001, 1'b0, 1'b0, 1'b0);
    cycle("b_wr1", 1'b1, 21'h00002, 1'b0, 1'b0, 1'b0);
    cycle("b_wr2", 1'b1, 21'h1FFFFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("b_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle("b_hold", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Overflow: ninth write dropped, contents intact.
    do_reset("r_ovf", 1'b0);
    for (int i = 0; i < 9; i++) cycle("o_wr", 1'b1, W'(32'h100 + i), 1'b0, 1'b0, 1'b0);
    cycle("o_idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle("o_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Full then 20 simultaneous read/write cycles; pointers wrap twice.
    do_reset("r_wrap", 1'b0);
    for (int i = 0; i < 8; i++) cycle("w_fill", 1'b1, W'(32'h200 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle("w_both", 1'b1, W'(32'h300 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < D && m_count > 0; i++) cycle("w_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Empty with simultaneous read/write: no fall-through.
    do_reset("r_empty", 1'b0);
    cycle("e_both", 1'b1, 21'h0ABCD, 1'b1, 1'b0, 1'b0);
    cycle("e_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Frame completion after drain, then an empty frame.
    do_reset("r_frame", 1'b0);
    cycle("f_wr0", 1'b1, 21'h00011, 1'b0, 1'b0, 1'b0);
    cycle("f_wr1", 1'b1, 21'h00022, 1'b0, 1'b0, 1'b0);
    cycle("f_done", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    cycle("f_rd0", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle("f_rd1", 1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle("f_after", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle("f_empty_done", 1'b0, '0, 1'b0, 1'b1, 1'b1);
    cycle("f_empty_after", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Mid-operation reset with a concurrent write discards everything.
    do_reset("r_mid", 1'b0);
    for (int i = 0; i < 5; i++) cycle("m_wr", 1'b1, W'(32'h400 + i), 1'b0, 1'b0, 1'b0);
    cycle("m_ovf_probe", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    do_reset("m_rst", 1'b1);
    cycle("m_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle("m_idle_done", 1'b0, '0, 1'b0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
